// File: rtl/readout_pkg.sv
// Shared types and helpers for the POCI readout sequencer: FSM state encoding,
// address-region classification and the channel-register stop-address formula.
package readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } readout_state_e;

    typedef enum logic [1:0] {
        RGN_ZERO = 2'd0,
        RGN_SPI  = 2'd1,
        RGN_CH   = 2'd2,
        RGN_NONE = 2'd3
    } readout_region_e;

    function automatic int ch_reg_stop_addr(input int start_addr, input int num_ch,
                                            input int regs_per_ch);
        return start_addr + num_ch * regs_per_ch - 1;
    endfunction

endpackage

// File: rtl/readout_addr_decode.sv
// Combinational register-address decoder: classifies cur_addr into the SPI-core
// window, a channel window (with channel index) or an unmapped region.
module readout_addr_decode
    import readout_pkg::*;
#(
    parameter int ADDR_W            = 7,
    parameter int NUM_CH            = 8,
    parameter int NUM_REGS_PER_CH   = 7,
    parameter int CH_REG_START_ADDR = 12,
    parameter int CH_W              = 3
) (
    input  logic [ADDR_W-1:0] cur_addr,
    output readout_region_e   region,
    output logic [CH_W-1:0]   ch_sel
);

    localparam int CH_REG_STOP_ADDR = ch_reg_stop_addr(CH_REG_START_ADDR, NUM_CH, NUM_REGS_PER_CH);
    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(CH_REG_START_ADDR);
    localparam logic [ADDR_W-1:0] STOP_A  = ADDR_W'(CH_REG_STOP_ADDR);
    localparam logic [ADDR_W-1:0] NREGS_A = ADDR_W'(NUM_REGS_PER_CH);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] idx;

    // Offset is only formed inside the channel window so it can never underflow.
    always_comb begin
        region = RGN_NONE;
        ch_sel = '0;
        offset = '0;
        idx    = '0;
        if (cur_addr == '0) begin
            region = RGN_ZERO;
        end else if (cur_addr < START_A) begin
            region = RGN_SPI;
        end else if (cur_addr <= STOP_A) begin
            region = RGN_CH;
            offset = cur_addr - START_A;
            idx    = offset / NREGS_A;
            ch_sel = CH_W'(idx);
        end
    end

endmodule

// File: rtl/poci_readout_seq.sv
// POCI readout sequencer: steps through register addresses REG_W bits at a time and
// muxes the matching serial source onto poci. Burst auto-increment needs READOUT_BURST_EN.
module poci_readout_seq
    import readout_pkg::*;
#(
    parameter int NUM_CH            = 8,
    parameter int NUM_REGS_PER_CH   = 7,
    parameter int CH_REG_START_ADDR = 12,
    parameter int ADDR_W            = 7,
    parameter int REG_W             = 8,
    localparam int CH_REG_STOP_ADDR = ch_reg_stop_addr(CH_REG_START_ADDR, NUM_CH, NUM_REGS_PER_CH),
    localparam int CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              spi_clk,
    input  logic              rst,
    input  logic              cs,
    input  logic [ADDR_W-1:0] addr,
    input  logic              addr_valid,
    input  logic              burst,
    input  logic [NUM_CH-1:0] poci_ch,
    input  logic              poci_spi,
    output logic              poci,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [CH_W-1:0]   ch_sel,
    output logic              busy,
    output logic              ovf
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] SHIFT = ST_SHIFT;
    localparam logic [1:0] DONE  = ST_DONE;

    localparam int BC_W = (REG_W > 1) ? $clog2(REG_W) : 1;
    localparam logic [BC_W-1:0]   BIT_LAST = BC_W'(REG_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

`ifdef READOUT_BURST_EN
    localparam logic BURST_EN = 1'b1;
`else
    localparam logic BURST_EN = 1'b0;
`endif

    generate
        if (CH_REG_STOP_ADDR > (2 ** ADDR_W) - 1) begin : g_addr_range_err
            $error("poci_readout_seq: channel register window exceeds ADDR_W address space");
        end
    endgenerate

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] cur_addr_reg, cur_addr_next;
    logic [BC_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic              burst_q_reg, burst_q_next;
    logic              ovf_reg, ovf_next;

    readout_region_e   region;
    logic [CH_W-1:0]   ch_sel_dec;

    always_comb begin
        state_next    = state_reg;
        cur_addr_next = cur_addr_reg;
        bit_cnt_next  = bit_cnt_reg;
        burst_q_next  = burst_q_reg;
        ovf_next      = ovf_reg;
        if (!cs) begin
            state_next    = IDLE;
            cur_addr_next = '0;
            bit_cnt_next  = '0;
            burst_q_next  = 1'b0;
            ovf_next      = 1'b0;
        end else begin
            case (state_reg)
                IDLE, SHIFT: begin
                    if (addr_valid) begin
                        state_next    = SHIFT;
                        cur_addr_next = addr;
                        bit_cnt_next  = '0;
                        burst_q_next  = burst & BURST_EN;
                    end else if (state_reg == SHIFT) begin
                        bit_cnt_next = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + 1'b1;
                        // End of a register: advance in burst mode, saturating into DONE at the top.
                        if (bit_cnt_reg == BIT_LAST && burst_q_reg) begin
                            if (cur_addr_reg == ADDR_MAX) begin
                                state_next = DONE;
                                ovf_next   = 1'b1;
                            end else begin
                                cur_addr_next = cur_addr_reg + 1'b1;
                            end
                        end
                    end
                end
                DONE: ;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cur_addr_reg <= '0;
            bit_cnt_reg  <= '0;
            burst_q_reg  <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cur_addr_reg <= cur_addr_next;
            bit_cnt_reg  <= bit_cnt_next;
            burst_q_reg  <= burst_q_next;
            ovf_reg      <= ovf_next;
        end
    end

    readout_addr_decode #(
        .ADDR_W           (ADDR_W),
        .NUM_CH           (NUM_CH),
        .NUM_REGS_PER_CH  (NUM_REGS_PER_CH),
        .CH_REG_START_ADDR(CH_REG_START_ADDR),
        .CH_W             (CH_W)
    ) u_addr_decode (
        .cur_addr(cur_addr_reg),
        .region  (region),
        .ch_sel  (ch_sel_dec)
    );

    always_comb begin
        poci = 1'b0;
        if (state_reg == SHIFT) begin
            case (region)
                RGN_SPI: poci = poci_spi;
                RGN_CH:  poci = poci_ch[ch_sel_dec];
                default: poci = 1'b0;
            endcase
        end
    end

    assign cur_addr = cur_addr_reg;
    assign ch_sel   = ch_sel_dec;
    assign busy     = (state_reg == SHIFT);
    assign ovf      = ovf_reg & BURST_EN;

endmodule

// File: tb/tb_poci_readout_seq.sv
// Self-checking bench for poci_readout_seq: directed address-map and burst checks
// followed by randomized traffic compared every cycle against a behavioural model.
module tb_poci_readout_seq;

    localparam int NUM_CH = 8;
    localparam int NREGS  = 7;
    localparam int START  = 12;
    localparam int STOP   = 67;
    localparam int REG_W  = 8;
    localparam int AMAX   = 127;

`ifdef READOUT_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic       spi_clk = 1'b0;
    logic       rst, cs, addr_valid, burst, poci_spi, poci, busy, ovf;
    logic [6:0] addr, cur_addr;
    logic [7:0] poci_ch;
    logic [2:0] ch_sel;

    int tests = 0;
    int fails = 0;

    poci_readout_seq dut (
        .spi_clk   (spi_clk),
        .rst       (rst),
        .cs        (cs),
        .addr      (addr),
        .addr_valid(addr_valid),
        .burst     (burst),
        .poci_ch   (poci_ch),
        .poci_spi  (poci_spi),
        .poci      (poci),
        .cur_addr  (cur_addr),
        .ch_sel    (ch_sel),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 spi_clk = ~spi_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 shifting, 2 done. In burst mode the address
    // is simply start + elapsed_cycles / REG_W, saturating at the top address.
    int m_mode = 0, m_start = 0, m_cyc = 0, m_addr = 0;
    bit m_burst = 0, m_ovf = 0;

    function automatic int exp_ch(input int a);
        return (a >= START && a <= STOP) ? (a - START) / NREGS : 0;
    endfunction

    function automatic logic exp_poci(input int a, input logic [7:0] ch, input logic spi);
        if (a == 0) return 1'b0;
        if (a < START) return spi;
        if (a <= STOP) return ch[(a - START) / NREGS];
        return 1'b0;
    endfunction

    task automatic model_clear();
        m_mode = 0; m_start = 0; m_cyc = 0; m_addr = 0; m_burst = 0; m_ovf = 0;
    endtask

    always begin
        int n;
        @(posedge spi_clk);
        if (rst || !cs) begin
            model_clear();
        end else if (m_mode != 2 && addr_valid) begin
            m_mode = 1; m_start = int'(addr); m_addr = int'(addr);
            m_cyc = 0; m_burst = burst & BURST_EN;
        end else if (m_mode == 1) begin
            m_cyc++;
            if (m_burst) begin
                n = m_start + m_cyc / REG_W;
                if (n > AMAX) begin
                    m_mode = 2; m_ovf = 1; m_addr = AMAX;
                end else begin
                    m_addr = n;
                end
            end
        end
        #1;
        check("cur_addr", 32'(cur_addr), 32'(m_addr));
        check("ch_sel", 32'(ch_sel), 32'(exp_ch(m_addr)));
        check("busy", 32'(busy), 32'(m_mode == 1));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("poci", 32'(poci), 32'((m_mode == 1) ? exp_poci(m_addr, poci_ch, poci_spi) : 1'b0));
    end

    always @(negedge spi_clk) begin
        poci_ch  = 8'($urandom);
        poci_spi = 1'($urandom);
    end

    task automatic start_txn(input int a, input bit b);
        addr       = 7'(a);
        burst      = b;
        addr_valid = 1'b1;
        @(negedge spi_clk);
        addr_valid = 1'b0;
        $display("[TB] txn addr=%0d burst=%0d", a, b);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; addr_valid = 1'b0; addr = '0; burst = 1'b0;
        poci_ch = '0; poci_spi = 1'b0;
        repeat (3) @(negedge spi_clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur_addr", 32'(cur_addr), 32'd0);
        check("rst_poci", 32'(poci), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0; cs = 1'b1;
        @(negedge spi_clk);

        start_txn(5, 1'b0);
        check("a5_cur_addr", 32'(cur_addr), 32'd5);
        check("a5_busy", 32'(busy), 32'd1);
        repeat (24) @(negedge spi_clk);
        check("a5_hold24", 32'(cur_addr), 32'd5);

        start_txn(26, 1'b0);
        check("a26_ch_sel", 32'(ch_sel), 32'd2);
        start_txn(67, 1'b0);
        check("a67_ch_sel", 32'(ch_sel), 32'd7);
        start_txn(68, 1'b0);
        check("a68_poci", 32'(poci), 32'd0);
        check("a68_ch_sel", 32'(ch_sel), 32'd0);

        start_txn(18, 1'b1);
        repeat (8) @(negedge spi_clk);
        check("b18_8_addr", 32'(cur_addr), BURST_EN ? 32'd19 : 32'd18);
        check("b18_8_ch_sel", 32'(ch_sel), BURST_EN ? 32'd1 : 32'd0);
        repeat (8) @(negedge spi_clk);
        check("b18_16_addr", 32'(cur_addr), BURST_EN ? 32'd20 : 32'd18);

        start_txn(127, 1'b1);
        repeat (8) @(negedge spi_clk);
        check("b127_busy", 32'(busy), BURST_EN ? 32'd0 : 32'd1);
        check("b127_ovf", 32'(ovf), BURST_EN ? 32'd1 : 32'd0);
        check("b127_addr", 32'(cur_addr), 32'd127);
        check("b127_poci", 32'(poci), 32'd0);
        cs = 1'b0;
        @(negedge spi_clk);
        check("cs_low_ovf", 32'(ovf), 32'd0);
        check("cs_low_busy", 32'(busy), 32'd0);
        cs = 1'b1;

        start_txn(30, 1'b0);
        cs = 1'b0; addr = 7'd40; addr_valid = 1'b1;
        @(negedge spi_clk);
        check("cs_beats_av_addr", 32'(cur_addr), 32'd0);
        check("cs_beats_av_busy", 32'(busy), 32'd0);
        addr_valid = 1'b0; cs = 1'b1;
        @(negedge spi_clk);

        start_txn(26, 1'b0);
        repeat (3) @(negedge spi_clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_addr", 32'(cur_addr), 32'd0);
        check("async_rst_ch_sel", 32'(ch_sel), 32'd0);
        check("async_rst_poci", 32'(poci), 32'd0);
        @(negedge spi_clk);
        rst = 1'b0;

        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            rst        = (r == 0);
            cs         = (r >= 4);
            addr_valid = ($urandom_range(0, 19) == 0);
            addr       = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(120, 127))
                                                     : 7'($urandom_range(0, 127));
            burst      = 1'($urandom);
            if (addr_valid && cs && !rst)
                $display("[TB] rand txn addr=%0d burst=%0d", addr, burst);
            @(negedge spi_clk);
        end
        rst = 1'b0; addr_valid = 1'b0;
        repeat (2) @(negedge spi_clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
